// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared single-port synchronous RAM.
// Each granted operation runs IDLE -> ACCESS -> CAPTURE, with one RAM operation in flight.
module ram_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic              busy,
    output logic              last_grant
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;

    logic [1:0] state;
    logic       gnt_port;
    logic       gnt_we;
    logic       elig0;
    logic       elig1;
    logic       pick1;

    // A port whose ack is high this cycle is still showing its old request, so it is not eligible.
    always_comb begin
        elig0 = req0 & ~ack0;
        elig1 = req1 & ~ack1;
        pick1 = elig1 & (~elig0 | ~last_grant);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            gnt_port    <= 1'b0;
            gnt_we      <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata0      <= '0;
            rdata1      <= '0;
            ram_address <= '0;
            ram_data    <= '0;
            ram_wren    <= 1'b0;
            busy        <= 1'b0;
            last_grant  <= 1'b1;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (elig0 | elig1) begin
                        state       <= ACCESS;
                        busy        <= 1'b1;
                        gnt_port    <= pick1;
                        gnt_we      <= pick1 ? we1 : we0;
                        last_grant  <= pick1;
                        ram_address <= pick1 ? addr1 : addr0;
                        ram_data    <= pick1 ? wdata1 : wdata0;
                        ram_wren    <= pick1 ? we1 : we0;
                    end
                end
                ACCESS: begin
                    ram_wren <= 1'b0;
                    state    <= CAPTURE;
                end
                CAPTURE: begin
                    // ram_q now reflects the address sampled at the end of ACCESS.
                    if (!gnt_we) begin
                        if (gnt_port) rdata1 <= ram_q;
                        else          rdata0 <= ram_q;
                    end
                    if (gnt_port) ack1 <= 1'b1;
                    else          ack0 <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ram_wren <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM, transaction-level memory/rdata/grant model,
// directed scenarios plus randomized single and contending operations.
module tb_ram_arbiter;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [4:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, ram_wren, busy, last_grant;
    logic [7:0] rdata0, rdata1, ram_data, ram_q;
    logic [4:0] ram_address;

    int total = 0;
    int bad = 0;

    logic [7:0] mem [32];
    logic [4:0] addr_q = '0;
    logic [7:0] ref_mem [32];
    logic [7:0] exp_rdata [2];
    int         lg_model = 1;
    logic       prev_wren = 1'b0;

    always #5 clock = ~clock;

    ram_arbiter #(.ADDR_W(5), .DATA_W(8)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
        .busy(busy), .last_grant(last_grant)
    );

    // Single-port RAM: address registered on the edge, q combinational from the registered address.
    always @(posedge clock) begin
        addr_q <= ram_address;
        if (ram_wren) mem[ram_address] <= ram_data;
    end
    assign ram_q = mem[addr_q];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (ram_wren) checkOutput("wren_consecutive", {31'd0, prev_wren}, 0);
        prev_wren = ram_wren;
    end

    task automatic applyStimulus(input int p, input logic r, input logic w,
                                 input logic [4:0] a, input logic [7:0] d);
        if (p == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic ackOf(input int p);
        return (p != 0) ? ack1 : ack0;
    endfunction

    function automatic logic [7:0] rdataOf(input int p);
        return (p != 0) ? rdata1 : rdata0;
    endfunction

    task automatic modelComplete(input int p, input logic w, input logic [4:0] a, input logic [7:0] d);
        if (w) ref_mem[a] = d;
        else   exp_rdata[p] = ref_mem[a];
        lg_model = p;
    endtask

    task automatic holdReset(input int cycles);
        resetn = 1'b0;
        applyStimulus(0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0);
        repeat (cycles) @(negedge clock);
        resetn = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        lg_model = 1;
    endtask

    task automatic singleOp(input int p, input logic w, input logic [4:0] a,
                            input logic [7:0] d, input string tag);
        int  wren_cycles = 0;
        int  other_acks = 0;
        int  lat = 0;
        bit  done = 0;
        @(negedge clock);
        applyStimulus(p, 1, w, a, d);
        for (int k = 1; k <= 10 && !done; k++) begin
            @(negedge clock);
            if (ram_wren) wren_cycles++;
            if (ackOf(1 - p)) other_acks++;
            if (ackOf(p)) begin
                done = 1;
                lat = k;
                applyStimulus(p, 0, 0, '0, '0);
                modelComplete(p, w, a, d);
                checkOutput({tag, "_rdata"}, rdataOf(p), exp_rdata[p]);
                checkOutput({tag, "_last_grant"}, last_grant, lg_model);
            end
        end
        if (!done) applyStimulus(p, 0, 0, '0, '0);
        checkOutput({tag, "_latency"}, lat, 3);
        checkOutput({tag, "_wren_cycles"}, wren_cycles, w ? 1 : 0);
        checkOutput({tag, "_other_ack"}, other_acks, 0);
    endtask

    task automatic pairOp(input logic w0, input logic [4:0] a0, input logic [7:0] d0,
                          input logic w1, input logic [4:0] a1, input logic [7:0] d1,
                          input string tag);
        logic       pw [2];
        logic [4:0] pa [2];
        logic [7:0] pd [2];
        int         lat [2];
        int         first;
        pw[0] = w0; pa[0] = a0; pd[0] = d0;
        pw[1] = w1; pa[1] = a1; pd[1] = d1;
        lat[0] = 0; lat[1] = 0;
        first = (lg_model == 1) ? 0 : 1;
        @(negedge clock);
        applyStimulus(0, 1, w0, a0, d0);
        applyStimulus(1, 1, w1, a1, d1);
        for (int k = 1; k <= 14 && (lat[0] == 0 || lat[1] == 0); k++) begin
            @(negedge clock);
            for (int p = 0; p < 2; p++) begin
                if (ackOf(p) && lat[p] == 0) begin
                    lat[p] = k;
                    applyStimulus(p, 0, 0, '0, '0);
                    modelComplete(p, pw[p], pa[p], pd[p]);
                    checkOutput({tag, "_rdata"}, rdataOf(p), exp_rdata[p]);
                end
            end
        end
        applyStimulus(0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0);
        checkOutput({tag, "_first_lat"}, lat[first], 3);
        checkOutput({tag, "_second_lat"}, lat[1 - first], 6);
        checkOutput({tag, "_last_grant"}, last_grant, 1 - first);
        lg_model = 1 - first;
    endtask

    task automatic fairness(input int nops);
        logic       fw [2];
        logic [4:0] fa [2];
        logic [7:0] fd [2];
        int         raised [2];
        int         issued = 0;
        int         done = 0;
        int         cycle = 0;
        int         expect_port;
        @(negedge clock);
        for (int p = 0; p < 2; p++) begin
            fw[p] = 1'($urandom_range(0, 1));
            fa[p] = 5'($urandom_range(0, 31));
            fd[p] = 8'($urandom);
            applyStimulus(p, 1, fw[p], fa[p], fd[p]);
            raised[p] = 0;
            issued++;
        end
        expect_port = (lg_model == 1) ? 0 : 1;
        while (done < nops && cycle < nops * 4 + 10) begin
            @(negedge clock);
            cycle++;
            for (int p = 0; p < 2; p++) begin
                if (ackOf(p)) begin
                    checkOutput("fair_order", p, expect_port);
                    checkOutput("fair_wait", {31'd0, (cycle - raised[p]) <= 6}, 1);
                    modelComplete(p, fw[p], fa[p], fd[p]);
                    checkOutput("fair_rdata", rdataOf(p), exp_rdata[p]);
                    expect_port = 1 - p;
                    done++;
                    if (issued < nops) begin
                        fw[p] = 1'($urandom_range(0, 1));
                        fa[p] = 5'($urandom_range(0, 31));
                        fd[p] = 8'($urandom);
                        applyStimulus(p, 1, fw[p], fa[p], fd[p]);
                        raised[p] = cycle;
                        issued++;
                    end else begin
                        applyStimulus(p, 0, 0, '0, '0);
                    end
                end
            end
        end
        applyStimulus(0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0);
        checkOutput("fair_count", done, nops);
    endtask

    initial begin
        int acks_seen;
        int lat;
        for (int i = 0; i < 32; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;

        $display("[TB] reset state");
        repeat (2) @(negedge clock);
        checkOutput("rst_ack0", ack0, 0);
        checkOutput("rst_ack1", ack1, 0);
        checkOutput("rst_rdata0", rdata0, 0);
        checkOutput("rst_rdata1", rdata1, 0);
        checkOutput("rst_ram_address", ram_address, 0);
        checkOutput("rst_ram_data", ram_data, 0);
        checkOutput("rst_ram_wren", ram_wren, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_last_grant", last_grant, 1);
        resetn = 1'b1;

        $display("[TB] single write then read on port 0");
        singleOp(0, 1, 5'd5, 8'hA7, "wr5");
        singleOp(0, 0, 5'd5, 8'h00, "rd5");
        checkOutput("rd5_value", rdata0, 8'hA7);

        $display("[TB] contention from reset");
        singleOp(1, 1, 5'd3, 8'h11, "setup3");
        singleOp(0, 1, 5'd4, 8'h22, "setup4");
        @(negedge clock);
        holdReset(2);
        pairOp(0, 5'd3, 8'h00, 0, 5'd4, 8'h00, "contend");
        checkOutput("contend_rdata0", rdata0, 8'h11);
        checkOutput("contend_rdata1", rdata1, 8'h22);
        checkOutput("contend_last_grant", last_grant, 1);

        $display("[TB] fairness under continuous requests");
        fairness(8);

        $display("[TB] randomized operations");
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0: singleOp(0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), "rnd_p0");
                1: singleOp(1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), "rnd_p1");
                default: pairOp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom),
                                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 8'($urandom), "rnd_pair");
            endcase
        end

        $display("[TB] reset during ACCESS");
        @(negedge clock);
        applyStimulus(1, 1, 1, 5'd31, 8'hFF);
        @(negedge clock);
        checkOutput("midop_busy", busy, 1);
        resetn = 1'b0;
        applyStimulus(1, 0, 0, '0, '0);
        @(negedge clock);
        checkOutput("midop_ack1", ack1, 0);
        checkOutput("midop_busy_cleared", busy, 0);
        checkOutput("midop_ram_wren", ram_wren, 0);
        checkOutput("midop_ram_address", ram_address, 0);
        checkOutput("midop_ram_data", ram_data, 0);
        checkOutput("midop_rdata0", rdata0, 0);
        checkOutput("midop_rdata1", rdata1, 0);
        checkOutput("midop_last_grant", last_grant, 1);
        resetn = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        lg_model = 1;
        acks_seen = 0;
        repeat (4) begin
            @(negedge clock);
            if (ack1) acks_seen++;
        end
        checkOutput("midop_no_ack", acks_seen, 0);
        singleOp(1, 1, 5'd31, 8'hFF, "reissue31");
        singleOp(1, 0, 5'd31, 8'h00, "read31");
        checkOutput("read31_value", rdata1, 8'hFF);

        $display("[TB] stale request through ack cycle");
        @(negedge clock);
        applyStimulus(0, 1, 0, 5'd5, 8'h00);
        lat = 0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clock);
            if (ack0) lat = k;
        end
        checkOutput("stale_latency", lat, 3);
        modelComplete(0, 0, 5'd5, 8'h00);
        checkOutput("stale_rdata", rdata0, exp_rdata[0]);
        @(negedge clock);
        checkOutput("stale_no_grant", busy, 0);
        applyStimulus(0, 0, 0, '0, '0);
        repeat (2) @(negedge clock);
        checkOutput("stale_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the shared single-port 32x8 synchronous RAM (ramlpm: address, clock, data, wren, q).
- Each requester issues one read or write at a time over a level req / single-cycle ack handshake.
- The block drives the RAM control pins, returns read data per port, and guarantees one RAM operation in flight.
- Sits between the RAM and its users, e.g. a switch-driven front panel and an internal fill/copy engine.

Parameters:
ADDR_W, 5, RAM address width (32 words)
DATA_W, 8, RAM data width

Ports:
clock  in  1  system clock; also drives the RAM clock
resetn  in  1  synchronous active-low reset
req0  in  1  port 0 request, level
we0  in  1  port 0 op: 1 write, 0 read; valid while req0
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  port 0 completion pulse, 1 cycle
rdata0  out  DATA_W  port 0 read data, valid from ack0 until next port-0 read ack
req1, we1, addr1, wdata1, ack1, rdata1  same as port 0, for port 1
ram_address  out  ADDR_W  to RAM address
ram_data  out  DATA_W  to RAM data
ram_wren  out  1  to RAM wren
ram_q  in  DATA_W  from RAM q (unregistered output, valid the cycle after the address edge)
busy  out  1  high in ACCESS and CAPTURE
last_grant  out  1  port index of the most recent grant

Behaviour:
- Clock and reset: one clock, named clock. Reset is synchronous and active-low, named resetn.
- Reset: all outputs are registered and cleared on a clock edge with resetn=0.
  - State IDLE; ack0 = ack1 = 0; rdata0 = rdata1 = 0.
  - ram_address = 0, ram_data = 0, ram_wren = 0, busy = 0.
  - last_grant = 1, so port 0 wins the first contention.
- FSM states: IDLE, ACCESS, CAPTURE.
- IDLE:
  - Eligible port = reqN=1 and ackN=0 in that cycle, so a stale req in its own ack cycle is ignored.
  - No eligible port: stay in IDLE.
  - One eligible port: grant it.
  - Both eligible: grant the port != last_grant.
  - On grant, at the edge: latch addrN into ram_address, wdataN into ram_data, weN into ram_wren; set last_grant=N; remember granted port and op; go to ACCESS.
- ACCESS:
  - ram_* outputs held stable; the RAM samples them at the ending edge.
  - At that edge: ram_wren <= 0; go to CAPTURE.
- CAPTURE:
  - ram_q holds the read word.
  - At the ending edge: if the op was a read, rdataN <= ram_q; for a write, rdataN is unchanged.
  - ackN <= 1 for the granted port only; go to IDLE.
- ack: high exactly one cycle, coinciding with IDLE.
  - The requester must drop or replace req in the ack cycle.
  - A new op may be raised on the cycle after ack.
- Latency: req sampled at edge E0 -> ack high after edge E2, i.e. 3 cycles.
  - Throughput: one op per 3 cycles.
  - Back-to-back contention alternates ports: 0, 1, 0, 1, ...
- Request inputs: ignored outside IDLE and may change freely then.
  - we/addr/wdata are captured only at the grant edge.
- ram_wren: high only during ACCESS of a write; never high two consecutive cycles.
- Reset mid-operation (resetn=0 in ACCESS or CAPTURE):
  - Op aborted at that edge, reset values applied, no ack issued.
  - A write whose ACCESS ending edge coincides with reset may or may not land in the RAM; the requester must re-issue.
- Address wrap: none. addr is used verbatim; 31 is a legal top address.

Test Plan:
- Reset: resetn=0 for 2 cycles -> all outputs 0, last_grant=1, busy=0, ram_wren=0.
- Single write then read on port 0: write addr0=5, wdata0=8'hA7 -> ram_wren=1 for exactly 1 cycle, ack0 3 cycles after req; then read addr0=5 -> rdata0=8'hA7 with ack0, ack1 never high.
- Contention: req0 and req1 both high in the same cycle from reset, reads of addr 3 (holding 8'h11) and addr 4 (holding 8'h22) -> port 0 acked first with rdata0=8'h11, port 1 acked 3 cycles later with rdata1=8'h22, last_grant=1.
- Fairness: both ports hold req continuously, re-raising after each ack -> grants alternate 0, 1, 0, 1 over 8 ops; no port waits more than 6 cycles.
- Reset mid-op: port 1 write addr 31, 8'hFF, resetn=0 during ACCESS -> no ack1, outputs at reset values next cycle; after re-issue, a read of addr 31 returns 8'hFF.
- Stale req: port 0 keeps req0 high through its ack cycle -> no second grant issued in that cycle.
